// File: rtl/disp_owner_arbiter.sv
// Round-robin owner arbiter for a shared 4-digit seven-segment display.
// One owner at a time holds the display. Ownership ends on release, on req
// drop, or on hold timeout while another requester waits. A guard gap always
// separates two owners.
module disp_owner_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_HOLD  = 2**22,
  parameter int GUARD_CYC = 4096,
  parameter int CW        = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     rel,
  input  logic [16*NUM_REQ-1:0]  digits_in,
  input  logic [5*NUM_REQ-1:0]   dp_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [2:0]             owner,
  output logic [3:0]             hex3,
  output logic [3:0]             hex2,
  output logic [3:0]             hex1,
  output logic [3:0]             hex0,
  output logic [4:0]             dp_out
);

  typedef enum logic [1:0] {IDLE, OWNED, GUARD} state_t;

  localparam logic [2:0]    LAST      = 3'(NUM_REQ-1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD-1);
  localparam logic [CW-1:0] GUARD_MAX = CW'(GUARD_CYC-1);

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt;
  logic [15:0]               hex_q;
  logic [NUM_REQ-1:0][15:0]  dig_a;
  logic [NUM_REQ-1:0][4:0]   dp_a;
  logic [15:0]               sel_dig;
  logic [4:0]                sel_dp;
  logic [2:0]                pick, pick_hi, pick_lo;
  logic                      found_hi;
  logic [NUM_REQ-1:0]        pick_oh;
  logic                      own_rel, own_req, other_req, end_own;

  assign dig_a = digits_in;
  assign dp_a  = dp_in;

  assign busy = (state != IDLE);
  assign hex3 = hex_q[15:12];
  assign hex2 = hex_q[11:8];
  assign hex1 = hex_q[7:4];
  assign hex0 = hex_q[3:0];

  // Owner's digit/dp slice; grant is one-hot of the owner while OWNED.
  always_comb begin
    sel_dig = '0;
    sel_dp  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_dig = sel_dig | dig_a[i];
        sel_dp  = sel_dp  | dp_a[i];
      end
    end
  end

  // Round-robin pick: lowest set req above owner, else lowest set req overall.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = 3'(i);
        if (3'(i) > owner) begin
          pick_hi  = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
    for (int i = 0; i < NUM_REQ; i++) pick_oh[i] = (3'(i) == pick);
  end

  // End-of-ownership detection; non-owner rel pulses are masked by grant.
  always_comb begin
    own_rel   = |(rel & grant);
    own_req   = |(req & grant);
    other_req = |(req & ~grant);
    end_own   = own_rel | ~own_req | ((cnt == HOLD_MAX) & other_req);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)              state_nxt = OWNED;
      OWNED:   if (end_own)           state_nxt = GUARD;
      GUARD:   if (cnt == GUARD_MAX)  state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant, owner, shared hold/guard counter and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant  <= '0;
      owner  <= LAST;
      cnt    <= '0;
      hex_q  <= '0;
      dp_out <= 5'b11111;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick_oh;
            owner <= pick;
            cnt   <= '0;
          end
        end
        OWNED: begin
          hex_q  <= sel_dig;
          dp_out <= sel_dp;
          if (end_own) begin
            grant <= '0;
            cnt   <= '0;
          end else if (cnt != HOLD_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        GUARD: begin
          if (cnt != GUARD_MAX) cnt <= cnt + CW'(1);
        end
        default: grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_owner_arbiter.sv
// Directed bench for disp_owner_arbiter with NUM_REQ=3, MAX_HOLD=8, GUARD_CYC=2.
module tb_disp_owner_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, rel;
  logic [47:0] digits_in;
  logic [14:0] dp_in;
  logic [2:0]  grant;
  logic        busy;
  logic [2:0]  owner;
  logic [3:0]  hex3, hex2, hex1, hex0;
  logic [4:0]  dp_out;

  int n_cmp = 0;
  int n_bad = 0;

  disp_owner_arbiter #(.NUM_REQ(3), .MAX_HOLD(8), .GUARD_CYC(2), .CW(23)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .digits_in(digits_in), .dp_in(dp_in),
    .grant(grant), .busy(busy), .owner(owner),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rel;
    logic [2:0]  g;
    logic        b;
    logic [2:0]  o;
    logic [15:0] hx;
    logic [4:0]  dp;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [27:0] pk(logic [2:0] g, logic b, logic [2:0] o,
                                     logic [15:0] hx, logic [4:0] dp);
    return {g, b, o, hx, dp};
  endfunction

  task automatic check(string name, logic [27:0] exp);
    logic [27:0] act;
    act = {grant, busy, owner, hex3, hex2, hex1, hex0, dp_out};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got g=%b b=%b o=%0d hex=%h dp=%b, want g=%b b=%b o=%0d hex=%h dp=%b",
               name, act[27:25], act[24], act[23:21], act[20:5], act[4:0],
               exp[27:25], exp[24], exp[23:21], exp[20:5], exp[4:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // req2 = 9876 / 01111, req1 = 1234 / 11110, req0 = 5555 / 10101
    digits_in = {16'h9876, 16'h1234, 16'h5555};
    dp_in     = {5'b01111, 5'b11110, 5'b10101};
    req = '0;
    rel = '0;
    reset = 1'b1;

    tbl[0]  = '{3'b110, 3'b000, 3'b010, 1'b1, 3'd1, 16'h0000, 5'b11111};
    tbl[1]  = '{3'b110, 3'b000, 3'b010, 1'b1, 3'd1, 16'h1234, 5'b11110};
    tbl[2]  = '{3'b110, 3'b010, 3'b000, 1'b1, 3'd1, 16'h1234, 5'b11110};
    tbl[3]  = '{3'b110, 3'b000, 3'b000, 1'b1, 3'd1, 16'h1234, 5'b11110};
    tbl[4]  = '{3'b110, 3'b000, 3'b000, 1'b0, 3'd1, 16'h1234, 5'b11110};
    tbl[5]  = '{3'b110, 3'b000, 3'b100, 1'b1, 3'd2, 16'h1234, 5'b11110};
    tbl[6]  = '{3'b100, 3'b000, 3'b100, 1'b1, 3'd2, 16'h9876, 5'b01111};
    tbl[7]  = '{3'b000, 3'b000, 3'b000, 1'b1, 3'd2, 16'h9876, 5'b01111};
    tbl[8]  = '{3'b011, 3'b000, 3'b000, 1'b1, 3'd2, 16'h9876, 5'b01111};
    tbl[9]  = '{3'b011, 3'b000, 3'b000, 1'b0, 3'd2, 16'h9876, 5'b01111};
    tbl[10] = '{3'b011, 3'b000, 3'b001, 1'b1, 3'd0, 16'h9876, 5'b01111};

    tick();
    tick();
    check("reset", pk(3'b000, 1'b0, 3'd2, 16'h0000, 5'b11111));
    reset = 1'b0;

    // Grant, release, guard, round robin, then owner 0 granted with req 011.
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      rel = tbl[i].rel;
      tick();
      check($sformatf("vec%0d", i), pk(tbl[i].g, tbl[i].b, tbl[i].o, tbl[i].hx, tbl[i].dp));
    end
    rel = '0;

    // Hold timeout: owner 0 keeps grant for 8 cycles while req1 waits.
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("hold%0d", k), pk(3'b001, 1'b1, 3'd0, 16'h5555, 5'b10101));
    end
    tick();
    check("timeout_drop", pk(3'b000, 1'b1, 3'd0, 16'h5555, 5'b10101));
    tick();
    check("timeout_guard2", pk(3'b000, 1'b1, 3'd0, 16'h5555, 5'b10101));
    tick();
    check("timeout_idle", pk(3'b000, 1'b0, 3'd0, 16'h5555, 5'b10101));
    tick();
    check("timeout_regrant", pk(3'b010, 1'b1, 3'd1, 16'h5555, 5'b10101));

    // Owner 1 drops req; single requester 0 takes over.
    req = 3'b001;
    tick();
    check("single_drop", pk(3'b000, 1'b1, 3'd1, 16'h1234, 5'b11110));
    tick();
    tick();
    check("single_idle", pk(3'b000, 1'b0, 3'd1, 16'h1234, 5'b11110));
    tick();
    check("single_grant", pk(3'b001, 1'b1, 3'd0, 16'h1234, 5'b11110));
    for (int k = 0; k < 100; k++) begin
      tick();
      check($sformatf("single_hold%0d", k), pk(3'b001, 1'b1, 3'd0, 16'h5555, 5'b10101));
    end

    // Owner drops req in the same cycle its saturated counter meets a competitor.
    req = 3'b010;
    tick();
    check("dual_end_guard1", pk(3'b000, 1'b1, 3'd0, 16'h5555, 5'b10101));
    tick();
    check("dual_end_guard2", pk(3'b000, 1'b1, 3'd0, 16'h5555, 5'b10101));
    tick();
    check("dual_end_idle", pk(3'b000, 1'b0, 3'd0, 16'h5555, 5'b10101));
    tick();
    check("dual_end_grant", pk(3'b010, 1'b1, 3'd1, 16'h5555, 5'b10101));
    tick();
    check("owned_pre_reset", pk(3'b010, 1'b1, 3'd1, 16'h1234, 5'b11110));

    // Asynchronous reset mid-OWNED, no clock edge in between.
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", pk(3'b000, 1'b0, 3'd2, 16'h0000, 5'b11111));
    req = 3'b111;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_grant", pk(3'b001, 1'b1, 3'd0, 16'h0000, 5'b11111));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_owner_arbiter.md
Name: disp_owner_arbiter

Overview:
- Shares one 4-digit seven-segment display between NUM_REQ independent requesters (e.g. counter, UART monitor, debug readout).
- Round-robin arbiter with one-hot registered grant, bounded hold time (preemption) and a guard gap between owners.
- Drives the hex3..hex0 / dp_in inputs of the existing display multiplexer from the current owner's digit bus.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- MAX_HOLD, 2**22, max cycles an owner keeps the display while another request is pending
- GUARD_CYC, 4096, cycles between one owner's release and the next grant
- CW, 23, width of internal hold/guard counter; must hold max(MAX_HOLD, GUARD_CYC)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request level per requester; held high while wanting the display
- rel  in  NUM_REQ  single-cycle release pulse per requester
- digits_in  in  16*NUM_REQ  requester i digits at [16i+15:16i], hex3 in the top nibble
- dp_in  in  5*NUM_REQ  requester i decimal points at [5i+4:5i]
- grant  out  NUM_REQ  one-hot ownership, registered
- busy  out  1  high in OWNED or GUARD
- owner  out  3  index of the current or last owner
- hex3, hex2, hex1, hex0  out  4 each  digits to the display mux, registered
- dp_out  out  5  decimal points to the display mux, registered; 1 = point off

Behaviour:
- Reset, async, all outputs:
  - state = IDLE, grant = 0, busy = 0, owner = NUM_REQ-1
  - hex3..hex0 = 0, dp_out = 5'b11111
  - rr pointer = NUM_REQ-1, so req[0] has top priority first
- States: IDLE, OWNED, GUARD.
- IDLE:
  - If any req is high, pick the first set bit searching upward from (owner+1) mod NUM_REQ.
  - Next edge: grant one-hot to that index, owner = index, hold counter = 0, state = OWNED.
  - Grant latency is 1 cycle from req sampled high.
  - With no req, stay in IDLE; outputs keep their last values.
- OWNED:
  - Each cycle, hex/dp outputs register the owner's slice of digits_in/dp_in, so outputs trail the inputs by 1 cycle.
  - Hold counter increments and saturates at MAX_HOLD-1.
  - End of ownership: rel[owner] pulse, OR req[owner] low, OR (hold counter == MAX_HOLD-1 AND any other req high).
  - On end of ownership, the next edge sets grant = 0, guard counter = 0, state = GUARD.
  - Several end conditions in the same cycle are handled identically.
  - rel/req from non-owners are ignored in OWNED; their req stays pending.
  - Owner alone with no competitor: never preempted, counter stays saturated.
- GUARD:
  - grant = 0, busy = 1; outputs freeze at the last owner's values.
  - Counter counts to GUARD_CYC-1, then state = IDLE.
  - Arbitration happens in IDLE on the following cycle, so a pending request is granted GUARD_CYC+1 cycles after grant drops.
  - A preempted owner that keeps req high rejoins arbitration at lowest priority, because the pointer has moved past it.
- owner updates only on a grant; it stays valid through GUARD and IDLE.
- owner output is zero-extended to 3 bits.
- grant is always zero or one-hot; it is never asserted in IDLE or GUARD.
- A reset assertion mid-OWNED or mid-GUARD returns to the reset values immediately; there is no partial release.
- A rel pulse with the matching req still high counts as release; if req stays high, that requester is re-arbitrated in IDLE at lowest priority.

Test Plan:
Bench settings: NUM_REQ=3, MAX_HOLD=8, GUARD_CYC=2.
- Reset then req=3'b110 (digits_in[31:16]=16'h1234, dp 5'b11110) -> grant=3'b010 one cycle later; hex3..0=1,2,3,4 and dp_out=5'b11110 the cycle after; owner=1.
- Owner 1 pulses rel[1] -> grant=0 next edge; outputs frozen for 2 cycles; IDLE; grant=3'b100 one cycle later (round robin skips past 1).
- req=3'b011 held, owner 0, no release -> after 8 owned cycles grant drops; 2 guard cycles + 1 IDLE cycle; grant=3'b010.
- Single requester req=3'b001 held for 100 cycles -> grant stays 3'b001 throughout, busy=1, no preemption.
- Owner drops req in the same cycle as timeout with a competitor pending -> exactly one GUARD entry; guard length exactly 2 cycles.
- Assert reset mid-OWNED -> grant=0, hex=0, dp_out=5'b11111, owner=2 immediately (asynchronous); after release req=3'b111 -> grant=3'b001.
